monitoreo_temperatura: RTL and testbench
========================================

# monitoreo_temperatura

Temperature-monitoring controller that classifies a sampled temperature as cold, normal or hot. It drives a heater or fan accordingly and raises an alert when an out-of-range condition persists. It sits between the temperature sensor interface and the actuator/alarm outputs, and is bound to the `interface_monitoreo` signal bundle in the top level (`monitoreo_top`). Temperatures are unsigned tenths of a degree, so 220 means 22.0 °C.

## Interface
- `TEMP_W`, default 10: width of the temperature input.
- `T_BAJO`, default 180: lowest value classified normal; below this is cold.
- `T_ALTO`, default 260: lowest value classified hot.
- `N_PERSIST`, default 6: consecutive out-of-range samples that trigger alert.
- `CNT_W`, default 4: persistence counter width; must satisfy 2^CNT_W > N_PERSIST.
- `clk` in 1: single system clock, rising edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `temp_entrada` in TEMP_W: sampled temperature, unsigned.
- `alerta` out 1: high while in ALERTA.
- `calefactor` out 1: heater enable.
- `ventilador` out 1: fan enable.
- `estado_actual` out 2: FSM state; 00 NORMAL, 01 BAJO, 10 ALTO, 11 ALERTA.
- `contador_salida` out CNT_W: current persistence count.

## Operation
- Classification each cycle:
  - cold if `temp_entrada` < T_BAJO;
  - hot if `temp_entrada` >= T_ALTO;
  - otherwise normal.
  - Boundaries: 179 is cold, 180 normal, 259 normal, 260 hot.
- Registered state includes `estado_actual`, counter `cnt`, and a cause bit `causa` (0 = cold, 1 = hot).
- Each rising edge:
  - Normal: state ← NORMAL, cnt ← 0. This applies from any state, including ALERTA (automatic recovery).
  - Cold:
    - If the previous cause was cold and the state was BAJO or ALERTA, cnt ← saturating cnt+1; otherwise cnt ← 1.
    - causa ← 0.
    - State ← ALERTA if the new cnt >= N_PERSIST, else BAJO.
  - Hot: symmetric with causa ← 1. State ← ALERTA if the new cnt >= N_PERSIST, else ALTO.
  - Direction change (cold↔hot) restarts cnt at 1 in the new direction.
- cnt saturates at N_PERSIST; it never wraps.
- Output decode (from registers only, no combinational path from `temp_entrada`):
  - `alerta` = (state == ALERTA).
  - `calefactor` = BAJO, or ALERTA with causa = 0 (subject to Configuration).
  - `ventilador` = ALTO, or ALERTA with causa = 1 (subject to Configuration).
  - `contador_salida` = cnt.
- `calefactor` and `ventilador` are never both 1.

## Timing
- Reset (asynchronous, immediate on `arst_n` low):
  - state NORMAL (00), cnt 0, causa 0.
  - All outputs 0.
  - Reset asserted mid-operation, including in ALERTA, applies the same values immediately.
- The first edge after release evaluates normally.
- Latency: a change on `temp_entrada` that is set up before edge k is reflected on all outputs after edge k (one cycle).
- Alert timing: the Nth consecutive same-direction out-of-range edge moves the state to ALERTA; with N=6, the 6th edge.
- A single normal sample clears alert and counter on that edge.
- No handshake; `temp_entrada` is sampled every cycle.

## Configuration
- `MON_ALERT_ACT_EN`:
  - Defined: in ALERTA the actuator for the recorded cause stays on (heater for cold, fan for hot).
  - Undefined: in ALERTA both `calefactor` and `ventilador` are 0 and only `alerta` is asserted.
  - All other behaviour is identical in both builds.

## Test plan
- Reset with 220 applied, then 4 random values in [180,259] -> state 00, alerta 0, counter 0, actuators 0 after each edge.
- Random value < 180 for 1 cycle -> state 01, calefactor 1, counter 1. Random value > 259 -> state 10, ventilador 1.
- 6 consecutive cold samples -> states 01 (×5) then 11 on the 6th edge, counter 1..6, alerta 1. Repeat with hot -> 10 (×5) then 11.
- Cold for 6 edges (ALERTA), then one value in [180,259] -> state 00, alerta 0, counter 0 after one edge.
- Transient: hot for 4 edges, then normal -> never 11, final state 00, alerta 0. Repeat with cold.
- Limits: 179 -> 01, then 180 -> 00; 259 -> 00, then 260 -> 10. Additionally, 5 cold then 1 hot -> state 10, counter 1; reset asserted in ALERTA -> immediate 00 and all outputs 0.

Source files
------------

// File: rtl/monitoreo_temperatura.sv
// Temperature monitor: classifies each sample as cold/normal/hot, drives heater or fan, raises alert on persistence.
// Optional macro MON_ALERT_ACT_EN keeps the cause's actuator on while in ALERTA.
module monitoreo_temperatura #(
    parameter int TEMP_W    = 10,
    parameter int T_BAJO    = 180,
    parameter int T_ALTO    = 260,
    parameter int N_PERSIST = 6,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [TEMP_W-1:0] temp_entrada,
    output logic              alerta,
    output logic              calefactor,
    output logic              ventilador,
    output logic [1:0]        estado_actual,
    output logic [CNT_W-1:0]  contador_salida
);

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        BAJO   = 2'b01,
        ALTO   = 2'b10,
        ALERTA = 2'b11
    } estado_t;

    localparam logic [TEMP_W-1:0] LIM_BAJO = TEMP_W'(T_BAJO);
    localparam logic [TEMP_W-1:0] LIM_ALTO = TEMP_W'(T_ALTO);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(N_PERSIST);
`ifdef MON_ALERT_ACT_EN
    localparam logic ALERT_ACT = 1'b1;
`else
    localparam logic ALERT_ACT = 1'b0;
`endif

    estado_t            estado_q, estado_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               causa_q, causa_d;
    logic               es_frio, es_caliente, sigue_racha;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    always_comb begin
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        causa_d     = causa_q;
        es_frio     = (temp_entrada < LIM_BAJO);
        es_caliente = (temp_entrada >= LIM_ALTO);
        // ALTO always carries causa=1 and BAJO causa=0, so any out-of-range
        // state with a matching cause means the run continues.
        sigue_racha = (estado_q != NORMAL) && (causa_q == es_caliente);

        if (!es_frio && !es_caliente) begin
            estado_d = NORMAL;
            cnt_d    = '0;
        end else begin
            cnt_d    = sigue_racha ? sat_inc(cnt_q) : CNT_W'(1);
            causa_d  = es_caliente;
            if (cnt_d >= CNT_MAX) begin
                estado_d = ALERTA;
            end else begin
                estado_d = es_caliente ? ALTO : BAJO;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            estado_q <= NORMAL;
            cnt_q    <= '0;
            causa_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            causa_q  <= causa_d;
        end
    end

    assign alerta          = (estado_q == ALERTA);
    assign calefactor      = (estado_q == BAJO) || ((estado_q == ALERTA) && ALERT_ACT && !causa_q);
    assign ventilador      = (estado_q == ALTO) || ((estado_q == ALERTA) && ALERT_ACT && causa_q);
    assign estado_actual   = estado_q;
    assign contador_salida = cnt_q;

endmodule

// File: tb/tb_monitoreo_temperatura.sv
// Self-checking bench for monitoreo_temperatura: directed table, hand sequences and randomized runs vs. a run-length model.
module tb_monitoreo_temperatura;

    localparam int N = 6;
`ifdef MON_ALERT_ACT_EN
    localparam bit ACT = 1'b1;
`else
    localparam bit ACT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [9:0] temp_entrada = 10'd220;
    logic       alerta, calefactor, ventilador;
    logic [1:0] estado_actual;
    logic [3:0] contador_salida;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: length of the current run of same-direction out-of-range samples.
    int m_len = 0;
    bit m_hot = 1'b0;

    monitoreo_temperatura dut (
        .clk(clk), .arst_n(arst_n), .temp_entrada(temp_entrada),
        .alerta(alerta), .calefactor(calefactor), .ventilador(ventilador),
        .estado_actual(estado_actual), .contador_salida(contador_salida)
    );

    always #5 clk = ~clk;

    typedef struct {
        int temp;
        int st;
        int cnt;
        bit hot;
    } vec_t;

    function automatic int exp_cal(input int st, input bit hot);
        return (st == 1 || (st == 3 && ACT && !hot)) ? 1 : 0;
    endfunction
    function automatic int exp_ven(input int st, input bit hot);
        return (st == 2 || (st == 3 && ACT && hot)) ? 1 : 0;
    endfunction

    function automatic int model_state();
        if (m_len == 0) return 0;
        if (m_len >= N) return 3;
        return m_hot ? 2 : 1;
    endfunction

    task automatic model_step(input int t);
        bit hot;
        if (t >= 180 && t < 260) begin
            m_len = 0;
        end else begin
            hot = (t >= 260);
            if (m_len > 0 && hot == m_hot) m_len = (m_len + 1 > N) ? N : m_len + 1;
            else m_len = 1;
            m_hot = hot;
        end
    endtask

    task automatic cmp(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int cnt, input bit hot);
        cmp({tag, ".estado"}, int'(estado_actual), st);
        cmp({tag, ".cnt"}, int'(contador_salida), cnt);
        cmp({tag, ".alerta"}, int'(alerta), (st == 3) ? 1 : 0);
        cmp({tag, ".calef"}, int'(calefactor), exp_cal(st, hot));
        cmp({tag, ".vent"}, int'(ventilador), exp_ven(st, hot));
        if (calefactor && ventilador) cmp({tag, ".both_act"}, 1, 0);
    endtask

    task automatic check_model(input string tag);
        check_all(tag, model_state(), (m_len > N) ? N : m_len, m_hot);
    endtask

    // Drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input int t);
        @(negedge clk);
        temp_entrada = 10'(t);
        @(posedge clk);
        model_step(t);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        temp_entrada = 10'd220;
        #1;
        m_len = 0;
        m_hot = 1'b0;
        check_all("reset", 0, 0, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    function automatic int rnd_class(input int c);
        case (c)
            0: return int'($urandom_range(179, 0));
            1: return int'($urandom_range(259, 180));
            default: return int'($urandom_range(1023, 260));
        endcase
    endfunction

    vec_t tbl[$];

    initial begin
        // Directed table: boundaries, run to alert, recovery, direction change.
        tbl.push_back('{220, 0, 0, 0});
        tbl.push_back('{179, 1, 1, 0});
        tbl.push_back('{180, 0, 0, 0});
        tbl.push_back('{259, 0, 0, 0});
        tbl.push_back('{260, 2, 1, 1});
        tbl.push_back('{100, 1, 1, 0});
        tbl.push_back('{0,   1, 2, 0});
        tbl.push_back('{50,  1, 3, 0});
        tbl.push_back('{120, 1, 4, 0});
        tbl.push_back('{178, 1, 5, 0});
        tbl.push_back('{10,  3, 6, 0});
        tbl.push_back('{90,  3, 6, 0});
        tbl.push_back('{200, 0, 0, 0});
        tbl.push_back('{300, 2, 1, 1});
        tbl.push_back('{1023,2, 2, 1});
        tbl.push_back('{400, 2, 3, 1});
        tbl.push_back('{260, 2, 4, 1});
        tbl.push_back('{500, 2, 5, 1});
        tbl.push_back('{700, 3, 6, 1});
        tbl.push_back('{150, 1, 1, 0});
        tbl.push_back('{150, 1, 2, 0});
        tbl.push_back('{150, 1, 3, 0});
        tbl.push_back('{150, 1, 4, 0});
        tbl.push_back('{150, 1, 5, 0});
        tbl.push_back('{270, 2, 1, 1});
        tbl.push_back('{259, 0, 0, 1});

        // Asynchronous reset: outputs must be zero before any clock edge.
        arst_n = 1'b0;
        #3;
        check_all("reset0", 0, 0, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;

        // Post-reset normal samples.
        for (int i = 0; i < 4; i++) begin
            step(rnd_class(1));
            check_model("post_rst");
        end

        foreach (tbl[i]) begin
            step(tbl[i].temp);
            check_all($sformatf("tbl%0d", i), tbl[i].st, tbl[i].cnt, tbl[i].hot);
        end

        // Transients of 4 samples then normal: never alert.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                step(rnd_class(d == 0 ? 2 : 0));
                cmp("transient.no_alert", int'(alerta), 0);
                cmp("transient.cnt", int'(contador_salida), i + 1);
            end
            step(rnd_class(1));
            check_all("transient.end", 0, 0, 1'b0);
        end

        // Reset asserted mid-cycle while in ALERTA.
        for (int i = 0; i < N; i++) step(rnd_class(0));
        check_all("pre_rst_alert", 3, N, 1'b0);
        #2;
        arst_n = 1'b0;
        #1;
        check_all("rst_in_alert", 0, 0, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        m_len = 0;
        m_hot = 1'b0;

        // Randomized runs against the model.
        for (int r = 0; r < 120; r++) begin
            int c;
            int len;
            c = int'($urandom_range(2, 0));
            len = int'($urandom_range(9, 1));
            for (int k = 0; k < len; k++) begin
                step(rnd_class(c));
                check_model("rand");
            end
        end

        do_reset();
        step(220);
        check_model("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
